btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
Front-end controller for the alarm-clock pushbuttons. Each of N_BTN raw button lines is synchronized, debounced and edge-qualified. The resulting press events are queued per button and shared onto a single event channel, using fixed-priority arbitration with a valid/ready handshake. The alarm-clock FSM consumes one button event per handshake instead of raw edge pulses.

Parameters:
N_BTN, 4, number of button channels (1..8)
DEB_CYC, 500000, stable cycles required to accept a press or a release (10 ms at 50 MHz)
HOLD_CYC, 25000000, held cycles before auto-repeat starts (AUTO_REPEAT_EN only)
RPT_CYC, 5000000, cycles between repeat events (AUTO_REPEAT_EN only)
CNT_W, 25, counter width; must hold max(DEB_CYC, HOLD_CYC, RPT_CYC)

Ports:
clk  input  1  system clock, all flops rising edge
rst_n  input  1  asynchronous active-low reset
btn_n  input  N_BTN  raw pushbuttons, active-low (0 = pressed), asynchronous to clk
evt_valid  output  1  an event is pending on evt_id
evt_id  output  $clog2(N_BTN) (min 1)  index of the granted button
evt_rpt  output  1  event is an auto-repeat rather than the initial press
evt_ready  input  1  consumer accepts the event this cycle
ovf  output  1  sticky: an event was dropped because its channel was already pending

Behaviour:
- Reset (async, rst_n=0): all sync flops = "released"; all channels in IDLE; counters = 0; pending = 0; evt_valid = 0, evt_id = 0, evt_rpt = 0, ovf = 0. Deassertion takes effect on the next clk edge. Reset mid-press: the button must pass through IDLE and full debounce again.
- Sync: 2-flop synchronizer per line, inverted internally to active-high "pr".
- Per-channel FSM, one counter per channel:
  - IDLE: pr=1 -> DEB_P, cnt = 0.
  - DEB_P: pr=0 -> IDLE; cnt reaches DEB_CYC-1 -> HELD, raise event (rpt=0), cnt = 0.
  - HELD: pr=0 -> DEB_R, cnt = 0; with AUTO_REPEAT_EN, cnt reaches HOLD_CYC-1 -> RPT, raise event (rpt=1), cnt = 0.
  - RPT: pr=0 -> DEB_R; cnt reaches RPT_CYC-1 -> raise event (rpt=1), cnt = 0.
  - DEB_R: pr=1 -> HELD, cnt = 0, no new event; cnt reaches DEB_CYC-1 -> IDLE.
- Latency: btn_n falling and stable -> pending set on clock edge 2 + DEB_CYC after the first sampled low. evt_valid is combinational from the pending flops, so it asserts in that same cycle.
- Pending: one flag plus one rpt bit per channel. Raising an event while the flag is already 1 and not being cleared that cycle drops the event and sets ovf (sticky until reset). If the event is raised on the same cycle its pending flag is cleared by a handshake, the new event is kept (flag stays 1) with no ovf.
- Arbitration: evt_valid = OR of pending flags. evt_id = lowest pending index; evt_rpt = that channel's rpt bit. A handshake (evt_valid & evt_ready) clears only the granted flag. evt_id/evt_rpt stay stable while evt_valid=1 and evt_ready=0, unless a lower index becomes pending; the fixed priority then pre-empts. Consumers treat the event as final only at the handshake.
- evt_ready with evt_valid=0 is ignored.

Optional Feature:
AUTO_REPEAT_EN: defined -> HELD/RPT auto-repeat as above; evt_rpt is valid. Undefined -> HELD exits only on release; RPT state and repeat counters are not built; evt_rpt is tied 0; HOLD_CYC/RPT_CYC are unused.

Decomposition:
- Package btn_pkg: chan_state_t enum (IDLE, DEB_P, HELD, RPT, DEB_R) and a localparam for the default CNT_W.
- Sub-module btn_chan: per-button synchronizer, counter, FSM, and raise/rpt outputs.
- Top: N_BTN btn_chan instances, the pending flags, the priority arbiter and ovf.

Test Plan (DEB_CYC=4, HOLD_CYC=20, RPT_CYC=8, N_BTN=4):
- Clean press of btn_n[2] held 10 cycles -> exactly one event, evt_id=2, evt_rpt=0, valid 2+4 cycles after the first low sample; evt_ready=1 clears it.
- Bounce: btn_n[0] low for 3 cycles then high, repeated 5 times -> no event; stable low -> one event.
- Simultaneous presses of btn 1 and btn 3 with evt_ready=0 -> evt_id=1 held; after one handshake evt_id=3; after a second handshake evt_valid=0.
- Auto-repeat: btn 0 held 60 cycles -> initial event, then rpt events at 20 and 28, 36, 44, 52 cycles after the initial one, all evt_rpt=1; the feature-off build gives one event only.
- Overflow: btn 2 pressed twice with evt_ready=0 -> second event dropped, ovf=1 and sticky; set-and-clear on the same cycle -> flag kept, ovf=0.
- Reset asserted in HELD -> all outputs 0 immediately; button still held after release of reset -> new event only after a full debounce.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton event front end.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_P,
    HELD,
    RPT,
    DEB_R
  } chan_state_t;

  localparam int CNT_W_DEF = 25;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Shared event channel: valid/ready handshake plus the sticky overflow flag.
interface btn_event_ctrl_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_rpt;
  logic            evt_ready;
  logic            ovf;

  modport master (output evt_valid, evt_id, evt_rpt, ovf, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_rpt, ovf, output evt_ready);
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce counter and press FSM.
// Auto-repeat (HELD -> RPT) is built only when AUTO_REPEAT_EN is defined.
//
//   state | meaning
//   IDLE  | released and stable
//   DEB_P | press seen, waiting for DEB_CYC stable pressed cycles
//   HELD  | press accepted, button still down
//   RPT   | auto-repeating every RPT_CYC cycles
//   DEB_R | release seen, waiting for DEB_CYC stable released cycles
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEB_CYC  = 500000,
`ifdef AUTO_REPEAT_EN
  parameter int HOLD_CYC = 25000000,
  parameter int RPT_CYC  = 5000000,
`endif
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic raise,
  output logic raise_rpt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);
`endif

  logic             sync_1;
  logic             pr;
  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Inverted on capture so reset ("released") clears both flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      pr     <= 1'b0;
    end else begin
      sync_1 <= ~btn_n;
      pr     <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    raise     = 1'b0;
    raise_rpt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pr) state_nxt = DEB_P;
      end
      DEB_P: begin
        if (!pr) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          raise     = 1'b1;
        end
      end
      HELD: begin
        if (!pr) begin
          state_nxt = DEB_R;
          cnt_nxt   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == HOLD_LAST) begin
          state_nxt = RPT;
          cnt_nxt   = '0;
          raise     = 1'b1;
          raise_rpt = 1'b1;
        end
`else
        else begin
          cnt_nxt = '0;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      RPT: begin
        if (!pr) begin
          state_nxt = DEB_R;
          cnt_nxt   = '0;
        end else if (cnt == RPT_LAST) begin
          cnt_nxt   = '0;
          raise     = 1'b1;
          raise_rpt = 1'b1;
        end
      end
`endif
      DEB_R: begin
        // A bounce back to pressed resumes HELD without a second press event.
        if (pr) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Pushbutton front end: N_BTN debounced channels, per-channel pending flags,
// fixed-priority (lowest index) event arbiter. Optional macro: AUTO_REPEAT_EN.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int DEB_CYC  = 500000,
  parameter int HOLD_CYC = 25000000,
  parameter int RPT_CYC  = 5000000,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  btn_event_ctrl_if.master evt
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  if (CNT_W < $clog2(max3(DEB_CYC, HOLD_CYC, RPT_CYC))) begin : g_cnt_w_too_small
    $error("btn_event_ctrl: CNT_W cannot hold the configured cycle counts");
  end

  logic [N_BTN-1:0] raise, raise_rpt;
  logic [N_BTN-1:0] pend, pend_rpt;
  logic [N_BTN-1:0] grant, clr;
  logic [ID_W-1:0]  grant_id;
  logic             any_pend, hs, ovf_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEB_CYC  (DEB_CYC),
`ifdef AUTO_REPEAT_EN
      .HOLD_CYC (HOLD_CYC),
      .RPT_CYC  (RPT_CYC),
`endif
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_n     (btn_n[i]),
      .raise     (raise[i]),
      .raise_rpt (raise_rpt[i])
    );
  end

  // Isolate the lowest set pending bit.
  assign grant    = pend & (~pend + N_BTN'(1));
  assign any_pend = |pend;
  assign hs       = any_pend & evt.evt_ready;
  assign clr      = grant & {N_BTN{hs}};

  always_comb begin
    grant_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) grant_id = ID_W'(i);
    end
  end

  // A raise on the cycle its flag is being handshaken replaces the old event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_rpt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend  <= (pend & ~clr) | raise;
      ovf_q <= ovf_q | (|(raise & pend & ~clr));
      for (int i = 0; i < N_BTN; i++) begin
        if (raise[i] && (!pend[i] || clr[i])) pend_rpt[i] <= raise_rpt[i];
      end
    end
  end

  assign evt.evt_valid = any_pend;
  assign evt.evt_id    = grant_id;
  assign evt.evt_rpt   = |(grant & pend_rpt);
  assign evt.ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench: directed scenarios plus random button/ready traffic,
// compared every cycle against a run-length reference model.
module tb_btn_event_ctrl;

  localparam int N_BTN = 4;
  localparam int DEB   = 4;
  localparam int HOLD  = 20;
  localparam int RPT   = 8;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
  localparam int EXP_AR_EVT = 6;
  localparam int EXP_AR_RPT = 5;
`else
  localparam bit AR = 1'b0;
  localparam int EXP_AR_EVT = 1;
  localparam int EXP_AR_RPT = 0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [N_BTN-1:0] btn_n = '1;

  btn_event_ctrl_if #(.ID_W(ID_W)) evt_if ();

  btn_event_ctrl #(
    .N_BTN(N_BTN), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .RPT_CYC(RPT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .evt   (evt_if.master)
  );

  always #5 clk = ~clk;

  // Reference model: a button changes accepted level after DEB+1 consecutive
  // opposite samples; repeats fire after HOLD, then every RPT, uninterrupted
  // pressed samples. Events reach the pending flags two edges after the sample.
  int lo_run[N_BTN], hi_run[N_BTN], held_len[N_BTN];
  bit pressed[N_BTN], ev_d1[N_BTN], ev_d2[N_BTN], rp_d1[N_BTN], rp_d2[N_BTN];
  bit m_pend[N_BTN], m_rpt[N_BTN];
  bit m_ovf;
  int n_chk = 0, n_pass = 0;
  int n_evt, n_rpt;

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      lo_run[i] = 0; hi_run[i] = 0; held_len[i] = 0; pressed[i] = 0;
      ev_d1[i] = 0; ev_d2[i] = 0; rp_d1[i] = 0; rp_d2[i] = 0;
      m_pend[i] = 0; m_rpt[i] = 0;
    end
    m_ovf = 0;
  endtask

  task automatic model_edge();
    int g;
    bit hs, low, ev, rp;
    g = -1;
    for (int i = 0; i < N_BTN; i++) if (m_pend[i]) begin g = i; break; end
    hs = (g >= 0) && (evt_if.evt_ready === 1'b1);
    for (int i = 0; i < N_BTN; i++) begin
      if (ev_d2[i]) begin
        if (m_pend[i] && !(hs && g == i)) m_ovf = 1;
        else begin m_pend[i] = 1; m_rpt[i] = rp_d2[i]; end
      end else if (hs && g == i) m_pend[i] = 0;
    end
    for (int i = 0; i < N_BTN; i++) begin
      low = (btn_n[i] == 1'b0); ev = 0; rp = 0;
      ev_d2[i] = ev_d1[i]; rp_d2[i] = rp_d1[i];
      if (!pressed[i]) begin
        if (low) begin
          lo_run[i]++;
          if (lo_run[i] == DEB + 1) begin
            pressed[i] = 1; ev = 1; lo_run[i] = 0; hi_run[i] = 0; held_len[i] = 0;
          end
        end else lo_run[i] = 0;
      end else if (!low) begin
        hi_run[i]++; held_len[i] = 0;
        if (hi_run[i] == DEB + 1) begin pressed[i] = 0; hi_run[i] = 0; lo_run[i] = 0; end
      end else if (hi_run[i] > 0) begin
        hi_run[i] = 0; held_len[i] = 0;
      end else begin
        held_len[i]++;
        if (AR && held_len[i] >= HOLD && (held_len[i] - HOLD) % RPT == 0) begin
          ev = 1; rp = 1;
        end
      end
      ev_d1[i] = ev; rp_d1[i] = rp;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  task automatic check_outputs();
    logic            exp_v, exp_r;
    logic [ID_W-1:0] exp_id;
    exp_v = 0; exp_r = 0; exp_id = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (m_pend[i]) begin exp_v = 1; exp_id = i[ID_W-1:0]; exp_r = m_rpt[i]; break; end
    end
    chk("evt_valid", 32'(evt_if.evt_valid), 32'(exp_v));
    chk("evt_id",    32'(evt_if.evt_id),    32'(exp_id));
    chk("evt_rpt",   32'(evt_if.evt_rpt),   32'(exp_r));
    chk("ovf",       32'(evt_if.ovf),       32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_id",    32'(evt_if.evt_id),    32'd0);
    chk("rst_rpt",   32'(evt_if.evt_rpt),   32'd0);
    chk("rst_ovf",   32'(evt_if.ovf),       32'd0);
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    model_reset();
    do_reset();
    steps(3);

    // Clean press of button 2: valid exactly 2+DEB edges after first low sample.
    btn_n[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("press_latency", 32'(evt_if.evt_valid), 32'(k >= 2 + DEB));
    end
    chk("press_id", 32'(evt_if.evt_id), 32'd2);
    btn_n[2] = 1'b1;
    evt_if.evt_ready = 1'b1;
    step();
    chk("press_cleared", 32'(evt_if.evt_valid), 32'd0);
    evt_if.evt_ready = 1'b0;
    steps(10);

    // Bouncing button 0 never settles long enough, then a stable press.
    for (int r = 0; r < 5; r++) begin
      btn_n[0] = 1'b0; steps(3);
      btn_n[0] = 1'b1; steps(3);
    end
    chk("bounce_no_event", 32'(evt_if.evt_valid), 32'd0);
    btn_n[0] = 1'b0; steps(8);
    chk("bounce_then_stable", 32'(evt_if.evt_valid), 32'd1);
    chk("bounce_then_stable_id", 32'(evt_if.evt_id), 32'd0);
    evt_if.evt_ready = 1'b1; step();
    evt_if.evt_ready = 1'b0;
    btn_n[0] = 1'b1; steps(10);

    // Simultaneous presses of 1 and 3: priority order, one per handshake.
    btn_n[1] = 1'b0; btn_n[3] = 1'b0;
    steps(8);
    chk("prio_first", 32'(evt_if.evt_id), 32'd1);
    evt_if.evt_ready = 1'b1; step();
    chk("prio_second", 32'(evt_if.evt_id), 32'd3);
    chk("prio_second_valid", 32'(evt_if.evt_valid), 32'd1);
    step();
    chk("prio_drained", 32'(evt_if.evt_valid), 32'd0);
    evt_if.evt_ready = 1'b0;
    btn_n[1] = 1'b1; btn_n[3] = 1'b1;
    steps(10);

    // Long hold of button 0 with the consumer always ready.
    n_evt = 0; n_rpt = 0;
    btn_n[0] = 1'b0;
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (k == 60) btn_n[0] = 1'b1;
      step();
      if (evt_if.evt_valid) begin
        n_evt++;
        if (evt_if.evt_rpt) n_rpt++;
      end
    end
    chk("hold_event_count", 32'(n_evt), 32'(EXP_AR_EVT));
    chk("hold_rpt_count", 32'(n_rpt), 32'(EXP_AR_RPT));
    evt_if.evt_ready = 1'b0;

    // Second press of button 2 while its first event is still pending.
    btn_n[2] = 1'b0; steps(8);
    btn_n[2] = 1'b1; steps(8);
    chk("ovf_before", 32'(evt_if.ovf), 32'd0);
    btn_n[2] = 1'b0; steps(8);
    chk("ovf_set", 32'(evt_if.ovf), 32'd1);
    btn_n[2] = 1'b1;
    evt_if.evt_ready = 1'b1; step();
    chk("ovf_drop_single", 32'(evt_if.evt_valid), 32'd0);
    steps(8);
    chk("ovf_sticky", 32'(evt_if.ovf), 32'd1);
    evt_if.evt_ready = 1'b0;

    // Raise coinciding with the handshake of the same channel keeps the event.
    do_reset();
    btn_n[2] = 1'b0; steps(8);
    btn_n[2] = 1'b1; steps(8);
    btn_n[2] = 1'b0; steps(2 + DEB);
    evt_if.evt_ready = 1'b1; step();
    chk("set_clr_kept", 32'(evt_if.evt_valid), 32'd1);
    chk("set_clr_no_ovf", 32'(evt_if.ovf), 32'd0);
    step();
    chk("set_clr_drained", 32'(evt_if.evt_valid), 32'd0);
    evt_if.evt_ready = 1'b0;
    btn_n[2] = 1'b1; steps(10);

    // Reset while button 1 is in HELD, then full debounce again.
    btn_n[1] = 1'b0; steps(10);
    chk("held_pending", 32'(evt_if.evt_valid), 32'd1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_redebounce", 32'(evt_if.evt_valid), 32'(k >= 2 + DEB));
    end
    btn_n[1] = 1'b1;
    evt_if.evt_ready = 1'b1; steps(10);

    // Random button activity and random consumer readiness.
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N_BTN; b++) begin
        if ($urandom_range(0, 99) < 3) btn_n[b] = ~btn_n[b];
      end
      evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
